mc_alu: RTL and testbench
=========================

// Module: mc_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the LC-3b datapath. Add, sub and the
//  logic and shift ops complete in one cycle. MULT and DIV use iterative
//  engines (shift-add and restoring divide) in place of combinational
//  '*' and '/'. Valid/ready request and response handshakes let the
//  control FSM stall on long ops. The result is held until accepted.
// PARAMETERS
//  WIDTH  16  operand/result width; >=4, power of two
//  SHW    $clog2(WIDTH)  derived; do not override
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  flush       in   1      sync abort of any in-flight/held op
//  req_valid   in   1      request present
//  req_ready   out  1      block can accept a request
//  aluop       in   4      opcode (see BEHAVIOUR)
//  a           in   WIDTH  operand A
//  b           in   WIDTH  operand B / shift amount
//  resp_valid  out  1      result registers valid
//  resp_ready  in   1      consumer accepts result
//  f           out  WIDTH  result (MULT low half, DIV quotient)
//  f_hi        out  WIDTH  MULT high half, DIV remainder, else 0
//  div0        out  1      DIV with b==0
//  bad_op      out  1      unknown opcode
// BEHAVIOUR
//  Opcodes: 0 add, 1 sub, 2 mult, 3 div, 4 and, 5 or, 6 xor, 7 not(~a),
//   8 pass(a), 9 sll, 10 srl, 11 sra, 12-15 unknown.
//  Reset (rst_n=0, any time, incl. mid-op) forces the following at once:
//   state=IDLE, resp_valid=0, f=0, f_hi=0, div0=0, bad_op=0.
//   req_ready=1 once rst_n=1.
//  FSM states: IDLE, MUL, DIV, DONE. req_ready=1 only in IDLE.
//  Accept = req_valid & req_ready at a rising edge. Operands and opcode
//   are captured; later changes to a/b/aluop have no effect.
//  IDLE -> DONE on accept of a 1-cycle op. resp_valid=1 the next cycle.
//   Latency is 1 cycle.
//  IDLE -> MUL or DIV on accept of op 2/3. The engine runs for WIDTH
//   cycles, then moves to DONE. resp_valid rises WIDTH+1 cycles after
//   the accept edge.
//  DONE -> IDLE on resp_valid & resp_ready. resp_valid drops the next
//   cycle. No new accept in the same cycle as a response handshake;
//   the next accept is one cycle later at the earliest.
//  While resp_valid=1 and resp_ready=0, f, f_hi, div0 and bad_op hold
//   stable.
//  flush=1 at an edge: state=IDLE, resp_valid=0. The result registers
//   may keep stale data. flush wins over an accept in the same cycle.
//  Arithmetic is modulo 2^WIDTH; MULT and DIV are unsigned.
//  MULT: {f_hi,f} = full 2*WIDTH-bit product.
//  DIV, b!=0: f = a/b, f_hi = a%b.
//  DIV, b==0: f=all ones, f_hi=a, div0=1, same WIDTH-cycle latency.
//  Shifts use the full b:
//   b>=WIDTH: sll/srl give 0; sra gives WIDTH copies of a[WIDTH-1].
//   b==0: result = a.
//  Unknown op: f=0, f_hi=0, bad_op=1, 1-cycle latency.
//  div0 and bad_op are valid only with resp_valid and are cleared on the
//   next accept. For non-MULT/DIV ops, f_hi=0.
// TESTING (WIDTH=16)
//  add a=7FFF b=0001 -> f=8000, f_hi=0, resp_valid 1 cycle after accept.
//   sub 0000-0001 -> FFFF.
//  mult 1234*0100 -> f=3400, f_hi=0012, resp_valid 17 cycles after
//   accept, req_ready=0 throughout. FFFF*FFFF -> f=0001, f_hi=FFFE.
//  div 0064/0007 -> f=000E, f_hi=0002, div0=0.
//   div 0005/0000 -> f=FFFF, f_hi=0005, div0=1.
//  sra 8000 by 0014 -> FFFF; sll 0001 by 0010 -> 0000;
//   srl 8000 by 000F -> 0001. Op 13 -> f=0, bad_op=1.
//  Backpressure: hold resp_ready=0 5 cycles after a mult. Outputs are
//   stable and req_ready=0 throughout. After the handshake, resp_valid=0
//   and req_ready=1 next cycle; back-to-back ops give correct results.
//  Drop rst_n during DIV cycle 5 -> all outputs 0 at once, no spurious
//   resp_valid. Repeat with flush -> IDLE next cycle, resp_valid=0; a new
//   add gives the correct result.

Source files
------------

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, iterative shift-add multiply
// and restoring divide, with valid/ready request and response handshakes.
module mc_alu #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_hi,
    output logic             div0,
    output logic             bad_op
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opnd;
    logic [SHW-1:0]   cnt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] quick;
    logic [SHW-1:0]   sh;
    logic             big;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    assign req_ready  = (state == IDLE) && rst_n;
    assign resp_valid = (state == DONE);
    assign accept     = req_valid && req_ready && !flush;
    assign last       = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (aluop)
                        OP_MUL:  state_nxt = MUL;
                        OP_DIV:  state_nxt = DIV;
                        default: state_nxt = DONE;
                    endcase
                end
            end
            MUL, DIV: if (last) state_nxt = DONE;
            DONE:     if (resp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Any set bit of b above the shift-index field means the shift is >= WIDTH.
    always_comb begin
        sh    = b[SHW-1:0];
        big   = |(b >> SHW);
        quick = '0;
        case (aluop)
            OP_ADD:  quick = a + b;
            OP_SUB:  quick = a - b;
            OP_AND:  quick = a & b;
            OP_OR:   quick = a | b;
            OP_XOR:  quick = a ^ b;
            OP_NOT:  quick = ~a;
            OP_PASS: quick = a;
            OP_SLL:  quick = big ? '0 : (a << sh);
            OP_SRL:  quick = big ? '0 : (a >> sh);
            OP_SRA:  quick = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
            default: quick = '0;
        endcase
    end

    // f/f_hi double as the engine registers: MUL keeps {hi,multiplier},
    // DIV keeps {remainder,dividend/quotient}; b==0 naturally yields ~0 and a.
    always_comb begin
        mul_sum   = {1'b0, f_hi} + (f[0] ? {1'b0, opnd} : '0);
        div_shift = {f_hi, f[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f      <= '0;
            f_hi   <= '0;
            div0   <= 1'b0;
            bad_op <= 1'b0;
            opnd   <= '0;
            cnt    <= '0;
        end else if (accept) begin
            cnt    <= '0;
            opnd   <= b;
            f_hi   <= '0;
            div0   <= (aluop == OP_DIV) && (b == '0);
            bad_op <= aluop[3] && aluop[2];
            if (aluop == OP_MUL || aluop == OP_DIV) f <= a;
            else                                    f <= quick;
        end else if (state == MUL) begin
            cnt  <= cnt + 1'b1;
            f_hi <= mul_sum[WIDTH:1];
            f    <= {mul_sum[0], f[WIDTH-1:1]};
        end else if (state == DIV) begin
            cnt <= cnt + 1'b1;
            if (!div_diff[WIDTH]) begin
                f_hi <= div_diff[WIDTH-1:0];
                f    <= {f[WIDTH-2:0], 1'b1};
            end else begin
                f_hi <= div_shift[WIDTH-1:0];
                f    <= {f[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu at WIDTH=16.
module tb_mc_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   aluop = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] f;
    logic [W-1:0] f_hi;
    logic         div0;
    logic         bad_op;

    int checks = 0;
    int errors = 0;

    mc_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .aluop      (aluop),
        .a          (a),
        .b          (b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .f          (f),
        .f_hi       (f_hi),
        .div0       (div0),
        .bad_op     (bad_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] ef, input logic [W-1:0] efh,
                       input logic ed0, input logic ebad, input int elat, input bit hold);
        int lat;
        int rr_bad;
        @(negedge clk);
        chk({tag, "_idle_rv"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        aluop = op;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        aluop = ~op;
        a = ~av;
        b = ~bv;
        lat = 0;
        rr_bad = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (req_ready) rr_bad++;
            if (resp_valid) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_busy_rdy"}, 32'(rr_bad), 32'd0);
        chk({tag, "_f"}, 32'(f), 32'(ef));
        chk({tag, "_fhi"}, 32'(f_hi), 32'(efh));
        chk({tag, "_div0"}, 32'(div0), 32'(ed0));
        chk({tag, "_bad"}, 32'(bad_op), 32'(ebad));
        if (!hold) handshake();
    endtask

    task automatic start_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        req_valid = 1'b1;
        aluop = op;
        a = av;
        b = bv;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk({tag, "_no_rv"}, 32'(seen), 32'd0);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] hold_f;
        logic [W-1:0] hold_fhi;
        int unstable;

        #2;
        chk("rst_rv", 32'(resp_valid), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_fhi", 32'(f_hi), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_bad", 32'(bad_op), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("add",   4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("sub",   4'd1,  16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("mul1",  4'd2,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0, 17, 1'b0);
        run("mul2",  4'd2,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17, 1'b0);
        run("div1",  4'd3,  16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 17, 1'b0);
        run("div0",  4'd3,  16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 17, 1'b0);
        run("and",   4'd4,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("or",    4'd5,  16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("xor",   4'd6,  16'hFFFF, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("not",   4'd7,  16'h1234, 16'h5555, 16'hEDCB, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("pass",  4'd8,  16'hABCD, 16'h1111, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("sra_b", 4'd11, 16'h8000, 16'h0014, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("sra_s", 4'd11, 16'h4000, 16'h0001, 16'h2000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("sll_b", 4'd9,  16'h0001, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("sll_4", 4'd9,  16'h0003, 16'h0004, 16'h0030, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("sll_0", 4'd9,  16'h0001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("srl_f", 4'd10, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("srl_h", 4'd10, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("op13",  4'd13, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b1, 1,  1'b0);
        run("clr",   4'd0,  16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b0, 1'b0, 1,  1'b0);

        // Backpressure on a multiply result, then back-to-back ops.
        run("bp",    4'd2,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0, 17, 1'b1);
        hold_f = f;
        hold_fhi = f_hi;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (f !== hold_f || f_hi !== hold_fhi || resp_valid !== 1'b1 || req_ready !== 1'b0)
                unstable++;
        end
        chk("bp_stable", 32'(unstable), 32'd0);
        handshake();
        run("b2b1",  4'd1,  16'h0010, 16'h0001, 16'h000F, 16'h0000, 1'b0, 1'b0, 1,  1'b0);
        run("b2b2",  4'd2,  16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0, 17, 1'b0);

        // Asynchronous reset in the middle of a divide-by-zero.
        start_op(4'd3, 16'hFFFF, 16'h0000);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_rv", 32'(resp_valid), 32'd0);
        chk("mrst_f", 32'(f), 32'd0);
        chk("mrst_fhi", 32'(f_hi), 32'd0);
        chk("mrst_div0", 32'(div0), 32'd0);
        chk("mrst_bad", 32'(bad_op), 32'd0);
        chk("mrst_rdy", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet("mrst", 20);
        run("post_rst", 4'd0, 16'h1234, 16'h1111, 16'h2345, 16'h0000, 1'b0, 1'b0, 1, 1'b0);

        // Flush in the middle of a divide.
        start_op(4'd3, 16'hFFFF, 16'h0000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_rv", 32'(resp_valid), 32'd0);
        chk("flush_rdy", 32'(req_ready), 32'd1);
        quiet("flush", 20);
        run("post_fl", 4'd0, 16'h0FFF, 16'h0001, 16'h1000, 16'h0000, 1'b0, 1'b0, 1, 1'b0);

        // Flush beats an accept in the same cycle.
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        aluop = 4'd0;
        a = 16'h0001;
        b = 16'h0001;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        quiet("fl_acc", 20);
        run("post_fa", 4'd6, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
